// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 19-bit CPU.
// Holds the PC, handshakes with instruction memory (req held until ack),
// registers the fetched word and exposes its decode fields, and applies
// jump/branch/call/ret redirects when the held instruction is consumed.
// Optional return-address stack: define FETCH_RAS_EN to build it; without it
// call behaves as jump, ret redirects to target_in, and the RAS flags read 0.
module fetch_unit #(
  parameter int                ADDR_W    = 19,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [18:0]       imem_rdata,
  input  logic              stall,
  input  logic              jump_in,
  input  logic              branch_taken_in,
  input  logic              call_in,
  input  logic              ret_in,
  input  logic [ADDR_W-1:0] target_in,
  output logic              instr_valid,
  output logic [18:0]       instr,
  output logic [4:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              ras_ovf,
  output logic              ras_unf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] ret_target_s;
  logic [18:0]       instr_r;
  logic [ADDR_W-1:0] instr_pc_r;
  logic              valid_r;
  logic              req_r;
  logic              accept_s;
  logic              consume_s;

  // A fetched word is captured only while a request is outstanding.
  assign accept_s  = (state_r == FETCH) && imem_ack;
  // The held instruction leaves the stage when downstream is ready.
  assign consume_s = (state_r == VALID) && !stall;
  // PC arithmetic wraps silently at 2^ADDR_W.
  assign pc_inc_s  = pc_r + ADDR_W'(1'b1);

`ifdef FETCH_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr_r;
  logic [PTR_W-1:0]  ras_top_s;
  logic [CNT_W-1:0]  ras_cnt_r;
  logic              ras_empty_s;
  logic              ras_full_s;
  logic              ras_ovf_r;
  logic              ras_unf_r;
  logic              do_push_s;
  logic              do_pop_s;
  logic [ADDR_W-1:0] ret_addr_s;

  // ret outranks call, so a simultaneous call never pushes.
  assign do_pop_s    = consume_s && ret_in;
  assign do_push_s   = consume_s && !ret_in && call_in;
  assign ret_addr_s  = instr_pc_r + ADDR_W'(1'b1);
  // ras_ptr_r is the next free slot; the top entry sits just below it.
  assign ras_top_s   = ras_ptr_r - PTR_W'(1'b1);
  assign ras_empty_s = (ras_cnt_r == {CNT_W{1'b0}});
  assign ras_full_s  = (ras_cnt_r == CNT_W'(RAS_DEPTH));
  // An empty stack falls back to the supplied target.
  assign ret_target_s = ras_empty_s ? target_in : ras_mem_r[ras_top_s];
  assign ras_ovf     = ras_ovf_r;
  assign ras_unf     = ras_unf_r;

  // Circular return-address stack with valid-entry count and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= {ADDR_W{1'b0}};
      end
      ras_ptr_r <= {PTR_W{1'b0}};
      ras_cnt_r <= {CNT_W{1'b0}};
      ras_ovf_r <= 1'b0;
      ras_unf_r <= 1'b0;
    end else if (do_push_s) begin
      // When full the write lands on the oldest entry and the count stays put.
      ras_mem_r[ras_ptr_r] <= ret_addr_s;
      ras_ptr_r            <= ras_ptr_r + PTR_W'(1'b1);
      if (ras_full_s) begin
        ras_ovf_r <= 1'b1;
      end else begin
        ras_cnt_r <= ras_cnt_r + CNT_W'(1'b1);
      end
    end else if (do_pop_s) begin
      if (ras_empty_s) begin
        ras_unf_r <= 1'b1;
      end else begin
        ras_ptr_r <= ras_top_s;
        ras_cnt_r <= ras_cnt_r - CNT_W'(1'b1);
      end
    end else begin
      ras_ptr_r <= ras_ptr_r;
    end
  end
`else
  assign ret_target_s = target_in;
  assign ras_ovf      = 1'b0;
  assign ras_unf      = 1'b0;
`endif

  // Next-state and next-PC selection; redirects act only on consumption.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    case (state_r)
      IDLE: begin
        state_next_s = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          state_next_s = VALID;
          pc_next_s    = pc_inc_s;
        end else begin
          state_next_s = FETCH;
        end
      end
      VALID: begin
        if (!stall) begin
          state_next_s = FETCH;
          if (ret_in) begin
            pc_next_s = ret_target_s;
          end else if (call_in || jump_in || branch_taken_in) begin
            pc_next_s = target_in;
          end else begin
            pc_next_s = pc_r;
          end
        end else begin
          state_next_s = VALID;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, PC and captured-instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
      instr_r    <= 19'd0;
      instr_pc_r <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      req_r   <= (state_next_s == FETCH);
      if (accept_s) begin
        instr_r    <= imem_rdata;
        instr_pc_r <= pc_r;
        valid_r    <= 1'b1;
      end else if (consume_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign opcode      = instr_r[18:14];
  assign rd          = instr_r[13:10];
  assign rs1         = instr_r[9:6];
  assign rs2         = instr_r[5:2];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; expectations adapt to FETCH_RAS_EN.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int ADDR_W = 19;
`ifdef FETCH_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [18:0]       imem_rdata;
  logic              stall;
  logic              jump_in, branch_taken_in, call_in, ret_in;
  logic [ADDR_W-1:0] target_in;
  logic              instr_valid;
  logic [18:0]       instr;
  logic [4:0]        opcode;
  logic [3:0]        rd, rs1, rs2;
  logic [ADDR_W-1:0] instr_pc;
  logic              ras_ovf, ras_unf;

  logic              ack_en;
  logic              use_fixed;
  logic [18:0]       fixed_word;
  int                n_tests = 0;
  int                n_fails = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .jump_in(jump_in), .branch_taken_in(branch_taken_in), .call_in(call_in),
    .ret_in(ret_in), .target_in(target_in), .instr_valid(instr_valid),
    .instr(instr), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .instr_pc(instr_pc), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  // Memory model: same-cycle ack, data equals address unless a fixed word is chosen.
  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = use_fixed ? fixed_word : imem_addr;

  // Advance to the next negedge with instr_valid high; redirects clear on the first edge.
  task automatic next_instr(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        jump_in = 1'b0; branch_taken_in = 1'b0; call_in = 1'b0; ret_in = 1'b0;
      end
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; ack_en = 1'b1; use_fixed = 1'b0; fixed_word = 19'd0;
    jump_in = 1'b0; branch_taken_in = 1'b0; call_in = 1'b0; ret_in = 1'b0;
    target_in = 19'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 19'd0 ||
        instr_pc !== 19'd0 || imem_addr !== 19'd0 || opcode !== 5'd0 ||
        ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
      $display("FAIL reset_state: req=%b v=%b instr=%h pc=%h addr=%h ovf=%b unf=%b, want all 0",
               imem_req, instr_valid, instr, instr_pc, imem_addr, ras_ovf, ras_unf);
      n_fails++;
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    bit found;
    for (int k = 0; k < 4; k++) begin
      next_instr(found);
      n_tests++;
      if (!found || instr_pc !== 19'(k) || instr !== 19'(k)) begin
        $display("FAIL seq_fetch[%0d]: found=%b pc=%h instr=%h, want pc=instr=%h",
                 k, found, instr_pc, instr, k);
        n_fails++;
      end
      n_tests++;
      if (imem_req !== 1'b0 || imem_addr !== 19'(k + 1)) begin
        $display("FAIL seq_valid_addr[%0d]: req=%b addr=%h, want req=0 addr=%h",
                 k, imem_req, imem_addr, k + 1);
        n_fails++;
      end
    end
    @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 19'd4) begin
      $display("FAIL seq_pulse: valid=%b req=%b addr=%h, want 0 1 00004",
               instr_valid, imem_req, imem_addr);
      n_fails++;
    end
  endtask

  task automatic test_stall();
    bit found;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'd4) begin
      $display("FAIL stall_pre: found=%b pc=%h, want 00004", found, instr_pc);
      n_fails++;
    end
    stall = 1'b1; jump_in = 1'b1; target_in = 19'h00100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (instr_valid !== 1'b1 || instr !== 19'd4 || imem_req !== 1'b0 ||
          instr_pc !== 19'd4) begin
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h req=%b pc=%h, want 1 00004 0 00004",
                 c, instr_valid, instr, imem_req, instr_pc);
        n_fails++;
      end
    end
    stall = 1'b0; jump_in = 1'b0;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'd5) begin
      $display("FAIL stall_release: found=%b pc=%h, want 00005", found, instr_pc);
      n_fails++;
    end
  endtask

  task automatic test_redirects();
    bit found;
    logic [ADDR_W-1:0] exp;
    jump_in = 1'b1; target_in = 19'h00010;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'h00010) begin
      $display("FAIL jump: found=%b pc=%h, want 00010", found, instr_pc);
      n_fails++;
    end
    call_in = 1'b1; target_in = 19'h00200;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'h00200) begin
      $display("FAIL call: found=%b pc=%h, want 00200", found, instr_pc);
      n_fails++;
    end
    ret_in = 1'b1; jump_in = 1'b1; target_in = 19'h00300;
    exp = RAS_ON ? 19'h00011 : 19'h00300;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== exp) begin
      $display("FAIL ret_over_jump: found=%b pc=%h, want %h", found, instr_pc, exp);
      n_fails++;
    end
    branch_taken_in = 1'b1; target_in = 19'h00040;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'h00040) begin
      $display("FAIL branch: found=%b pc=%h, want 00040", found, instr_pc);
      n_fails++;
    end
  endtask

  task automatic test_redirect_in_fetch();
    bit found;
    ack_en = 1'b0;
    @(negedge clk);
    jump_in = 1'b1; target_in = 19'h00155;
    @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 19'h00041) begin
      $display("FAIL fetch_wait: valid=%b req=%b addr=%h, want 0 1 00041",
               instr_valid, imem_req, imem_addr);
      n_fails++;
    end
    jump_in = 1'b0; ack_en = 1'b1;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'h00041) begin
      $display("FAIL fetch_ignore_redirect: found=%b pc=%h, want 00041", found, instr_pc);
      n_fails++;
    end
  endtask

  task automatic test_ras();
    bit found;
    logic [ADDR_W-1:0] exp;
    logic [ADDR_W-1:0] pops [5];
    pops[0] = 19'h00701; pops[1] = 19'h00601; pops[2] = 19'h00501;
    pops[3] = 19'h00401; pops[4] = 19'h000AA;
    jump_in = 1'b1; target_in = 19'h000F0;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'h000F0) begin
      $display("FAIL ras_setup: found=%b pc=%h, want 000f0", found, instr_pc);
      n_fails++;
    end
    for (int i = 0; i < 5; i++) begin
      call_in = 1'b1; target_in = 19'h00400 + 19'(i * 256);
      next_instr(found);
      n_tests++;
      if (!found || instr_pc !== 19'h00400 + 19'(i * 256)) begin
        $display("FAIL ras_call[%0d]: found=%b pc=%h, want %h",
                 i, found, instr_pc, 19'h00400 + 19'(i * 256));
        n_fails++;
      end
      n_tests++;
      if (ras_ovf !== ((i == 4) && RAS_ON)) begin
        $display("FAIL ras_ovf[%0d]: got %b want %b", i, ras_ovf, (i == 4) && RAS_ON);
        n_fails++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      ret_in = 1'b1; target_in = 19'h000AA;
      exp = RAS_ON ? pops[i] : 19'h000AA;
      next_instr(found);
      n_tests++;
      if (!found || instr_pc !== exp) begin
        $display("FAIL ras_ret[%0d]: found=%b pc=%h, want %h", i, found, instr_pc, exp);
        n_fails++;
      end
      n_tests++;
      if (ras_unf !== ((i == 4) && RAS_ON)) begin
        $display("FAIL ras_unf[%0d]: got %b want %b", i, ras_unf, (i == 4) && RAS_ON);
        n_fails++;
      end
    end
  endtask

  task automatic test_wrap_and_fields();
    bit found;
    jump_in = 1'b1; target_in = 19'h7FFFF;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'h7FFFF || imem_addr !== 19'h00000) begin
      $display("FAIL pc_wrap: found=%b pc=%h addr=%h, want 7ffff 00000",
               found, instr_pc, imem_addr);
      n_fails++;
    end
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'h00000) begin
      $display("FAIL pc_wrap_fetch: found=%b pc=%h, want 00000", found, instr_pc);
      n_fails++;
    end
    use_fixed = 1'b1; fixed_word = 19'b10110_1100_1010_0111_01;
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'h00001 || instr !== 19'b10110_1100_1010_0111_01 ||
        opcode !== 5'b10110 || rd !== 4'b1100 || rs1 !== 4'b1010 || rs2 !== 4'b0111) begin
      $display("FAIL fields: pc=%h instr=%b op=%b rd=%h rs1=%h rs2=%h, want 00001 op=10110 c a 7",
               instr_pc, instr, opcode, rd, rs1, rs2);
      n_fails++;
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found;
    ack_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 19'h00002) begin
      $display("FAIL arst_pre: req=%b addr=%h, want 1 00002", imem_req, imem_addr);
      n_fails++;
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (imem_req !== 1'b0 || imem_addr !== 19'd0 || instr_valid !== 1'b0 ||
        instr !== 19'd0 || instr_pc !== 19'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
      $display("FAIL arst_clear: req=%b addr=%h v=%b instr=%h pc=%h ovf=%b unf=%b, want all 0",
               imem_req, imem_addr, instr_valid, instr, instr_pc, ras_ovf, ras_unf);
      n_fails++;
    end
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      $display("FAIL arst_hold: valid=%b req=%b, want 0 0", instr_valid, imem_req);
      n_fails++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 19'd0) begin
      $display("FAIL arst_first_req: req=%b addr=%h, want 1 00000", imem_req, imem_addr);
      n_fails++;
    end
    next_instr(found);
    n_tests++;
    if (!found || instr_pc !== 19'd0 || instr !== 19'd0) begin
      $display("FAIL arst_first_fetch: found=%b pc=%h instr=%h, want 00000",
               found, instr_pc, instr);
      n_fails++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirects();
    test_redirect_in_fetch();
    test_ras();
    test_wrap_and_fields();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
